// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared opcodes, instruction field positions and fetch state encoding
package imem_pkg;

    localparam int ADDR_W_DEF    = 8;
    localparam int INSTR_W_DEF   = 8;
    localparam int MEM_DEPTH_DEF = 32;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_J   = 2'b11;

    localparam int OPC_HI = 7;
    localparam int OPC_LO = 6;
    localparam int RS_HI  = 5;
    localparam int RS_LO  = 4;
    localparam int RT_HI  = 3;
    localparam int RT_LO  = 2;
    localparam int RD_HI  = 1;
    localparam int RD_LO  = 0;
    localparam int JT_HI  = 5;
    localparam int JT_LO  = 0;
    localparam int JT_W   = JT_HI - JT_LO + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

    function automatic logic is_jump(input logic [1:0] opcode);
        return opcode == OP_J;
    endfunction

endpackage

// File: rtl/fetch_pc_next.sv
// rtl/fetch_pc_next.sv - next-PC mux: redirect over jump over PC+1, all wrapped to MEM_DEPTH
module fetch_pc_next
    import imem_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    input  logic              jump_take,
    input  logic [JT_W-1:0]   jump_target,
    output logic [ADDR_W-1:0] next_pc
);

    // MEM_DEPTH is a power of two, so "mod MEM_DEPTH" is a plain bit mask
    localparam logic [ADDR_W-1:0] WRAP_MASK = ADDR_W'(MEM_DEPTH - 1);

    // Later assignments win: redirect beats jump beats sequential
    always_comb begin
        next_pc = (pc + ADDR_W'(1)) & WRAP_MASK;
        if (jump_take) begin
            next_pc = ADDR_W'(jump_target) & WRAP_MASK;
        end
        if (redirect_valid) begin
            next_pc = redirect_addr & WRAP_MASK;
        end
    end

endmodule

// File: rtl/imem_fetch.sv
// rtl/imem_fetch.sv - fetch stage: PC, IR and valid/ready hand-off to decode (option: IMEM_FETCH_JUMP_EN)
module imem_fetch
    import imem_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int INSTR_W   = INSTR_W_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int RESET_PC  = 0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  Read_Address,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               fetch_en,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [15:0]        instr_count
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               if_valid_q, if_valid_d;
    logic [INSTR_W-1:0] if_instr_q, if_instr_d;
    logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
    logic [15:0]        count_q, count_d;

    logic               slot_free;
    logic               load;
    logic               jump_take;
    logic [ADDR_W-1:0]  next_pc;

    assign slot_free = !if_valid_q || if_ready;
    assign load      = fetch_en && slot_free && !redirect_valid;

`ifdef IMEM_FETCH_JUMP_EN
    // Jumps resolve here so the target is fetched on the very next cycle
    assign jump_take = load && is_jump(instruction[OPC_HI:OPC_LO]);
`else
    assign jump_take = 1'b0;
`endif

    fetch_pc_next #(
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_pc_next (
        .pc             (pc_q),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .jump_take      (jump_take),
        .jump_target    (instruction[JT_HI:JT_LO]),
        .next_pc        (next_pc)
    );

    // Next-state: run state, PC advance, IR load/flush/drain and acceptance counter
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        count_d    = count_q + 16'(if_valid_q && if_ready);

        case (state_q)
            ST_IDLE: if (fetch_en)  state_d = ST_RUN;
            ST_RUN:  if (!fetch_en) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (redirect_valid) begin
            pc_d       = next_pc;
            if_valid_d = 1'b0;
        end else if (load) begin
            pc_d       = next_pc;
            if_valid_d = 1'b1;
            if_instr_d = instruction;
            if_pc_d    = pc_q;
        end else if (if_valid_q && if_ready) begin
            if_valid_d = 1'b0;
        end
    end

    // State, PC, IR and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= ADDR_W'(RESET_PC);
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            count_q    <= count_d;
        end
    end

    assign Read_Address = pc_q;
    assign if_valid     = if_valid_q;
    assign if_instr     = if_instr_q;
    assign if_pc        = if_pc_q;
    assign instr_count  = count_q;

endmodule
